// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Multi-cycle RV64M divide/remainder unit. Accepts one op per
//               valid/ready handshake, decodes the one-hot div/rem info
//               vectors, and computes the result with a radix-2 restoring
//               divider (one quotient bit per cycle). Division by zero and
//               signed overflow bypass the iteration and finish in one cycle.
// Ports       : clk, rst (async, active-low)
//               div_i_valid/div_i_ready      - request handshake
//               div_i_div_info/div_i_rem_info - one-hot op select
//               div_i_src1/div_i_src2        - dividend / divisor
//               div_i_rd                     - destination register
//               div_i_flush                  - abort, including pending result
//               div_o_valid/div_o_ready      - result handshake
//               div_o_result/div_o_rd        - final result and its rd
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_i_valid,
    output logic        div_i_ready,
    input  logic [3:0]  div_i_div_info,
    input  logic [3:0]  div_i_rem_info,
    input  logic [63:0] div_i_src1,
    input  logic [63:0] div_i_src2,
    input  logic [4:0]  div_i_rd,
    input  logic        div_i_flush,
    output logic        div_o_valid,
    input  logic        div_o_ready,
    output logic [63:0] div_o_result,
    output logic [4:0]  div_o_rd
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [63:0] C_MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] C_MIN32 = 64'hFFFF_FFFF_8000_0000;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic [63:0] r_prem;     // partial remainder
    logic [63:0] r_dvd;      // dividend bits shift out the top, quotient bits shift in
    logic [63:0] r_dvsr;     // divisor magnitude
    logic        r_word;
    logic        r_rem;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [63:0] r_result;
    logic [4:0]  r_rd;

    // ------------------------------------------------------------------
    // Request decode (fixed priority: div_info[3..0], then rem_info[3..0])
    // ------------------------------------------------------------------
    logic w_op_any;
    logic w_signed;
    logic w_word;
    logic w_is_rem;

    always_comb begin
        w_signed = 1'b0;
        w_word   = 1'b0;
        w_is_rem = 1'b0;
        w_op_any = (|div_i_div_info) | (|div_i_rem_info);
        if (div_i_div_info[3]) begin
            w_signed = 1'b1;
        end else if (div_i_div_info[2]) begin
            w_signed = 1'b0;
        end else if (div_i_div_info[1]) begin
            w_signed = 1'b1;
            w_word   = 1'b1;
        end else if (div_i_div_info[0]) begin
            w_word   = 1'b1;
        end else if (div_i_rem_info[3]) begin
            w_is_rem = 1'b1;
            w_signed = 1'b1;
        end else if (div_i_rem_info[2]) begin
            w_is_rem = 1'b1;
        end else if (div_i_rem_info[1]) begin
            w_is_rem = 1'b1;
            w_signed = 1'b1;
            w_word   = 1'b1;
        end else if (div_i_rem_info[0]) begin
            w_is_rem = 1'b1;
            w_word   = 1'b1;
        end
    end

    // Operands extended to 64 bits according to width and signedness
    logic [63:0] w_a;
    logic [63:0] w_b;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [63:0] w_mag_a;
    logic [63:0] w_mag_b;
    logic        w_div0;
    logic        w_ovf;
    logic [63:0] w_special_val;
    logic [63:0] w_special_res;

    assign w_a = w_word ? (w_signed ? sext32(div_i_src1[31:0]) : {32'd0, div_i_src1[31:0]})
                        : div_i_src1;
    assign w_b = w_word ? (w_signed ? sext32(div_i_src2[31:0]) : {32'd0, div_i_src2[31:0]})
                        : div_i_src2;

    assign w_a_neg = w_signed & w_a[63];
    assign w_b_neg = w_signed & w_b[63];
    assign w_mag_a = w_a_neg ? (64'd0 - w_a) : w_a;
    assign w_mag_b = w_b_neg ? (64'd0 - w_b) : w_b;

    assign w_div0 = (w_b == 64'd0);
    // Word operands are already sign-extended, so the most-negative word
    // value appears as its 64-bit sign extension.
    assign w_ovf  = w_signed && (w_b == {64{1'b1}}) &&
                    (w_a == (w_word ? C_MIN32 : C_MIN64));

    assign w_special_val = w_div0 ? (w_is_rem ? w_a : {64{1'b1}})
                                  : (w_is_rem ? 64'd0 : w_a);
    assign w_special_res = w_word ? sext32(w_special_val[31:0]) : w_special_val;

    // ------------------------------------------------------------------
    // Restoring step. The trial subtraction is 65 bits wide so that the
    // shifted remainder's carry-out is accounted for with full 64-bit
    // divisors.
    // ------------------------------------------------------------------
    logic [64:0] w_diff;
    logic [63:0] w_shift_lo;
    logic        w_qbit;
    logic [63:0] w_prem_nx;
    logic [63:0] w_dvd_nx;

    assign w_diff     = {r_prem, r_dvd[63]} - {1'b0, r_dvsr};
    assign w_shift_lo = {r_prem[62:0], r_dvd[63]};
    assign w_qbit     = ~w_diff[64];
    assign w_prem_nx  = w_qbit ? w_diff[63:0] : w_shift_lo;
    assign w_dvd_nx   = {r_dvd[62:0], w_qbit};

    // Fixup applied on the last step's values as the unit enters DONE
    logic [63:0] w_q_mag;
    logic [63:0] w_q_fix;
    logic [63:0] w_r_fix;
    logic [63:0] w_sel;
    logic [63:0] w_calc_res;

    assign w_q_mag    = r_word ? {32'd0, w_dvd_nx[31:0]} : w_dvd_nx;
    assign w_q_fix    = r_neg_q ? (64'd0 - w_q_mag) : w_q_mag;
    assign w_r_fix    = r_neg_r ? (64'd0 - w_prem_nx) : w_prem_nx;
    assign w_sel      = r_rem ? w_r_fix : w_q_fix;
    assign w_calc_res = r_word ? sext32(w_sel[31:0]) : w_sel;

    // ------------------------------------------------------------------
    // Control and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 6'd0;
            r_prem   <= 64'd0;
            r_dvd    <= 64'd0;
            r_dvsr   <= 64'd0;
            r_word   <= 1'b0;
            r_rem    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= 64'd0;
            r_rd     <= 5'd0;
        end else if (div_i_flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (div_i_valid && w_op_any) begin
                        r_rd    <= div_i_rd;
                        r_word  <= w_word;
                        r_rem   <= w_is_rem;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        if (w_div0 || w_ovf) begin
                            r_result <= w_special_res;
                            r_state  <= S_DONE;
                        end else begin
                            r_prem  <= 64'd0;
                            // Word dividends sit in the top half so the
                            // quotient lands in the low 32 bits after 32 steps.
                            r_dvd   <= w_word ? {w_mag_a[31:0], 32'd0} : w_mag_a;
                            r_dvsr  <= w_mag_b;
                            r_cnt   <= w_word ? 6'd31 : 6'd63;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_prem <= w_prem_nx;
                    r_dvd  <= w_dvd_nx;
                    if (r_cnt == 6'd0) begin
                        r_result <= w_calc_res;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                S_DONE: begin
                    if (div_o_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign div_i_ready  = (r_state == S_IDLE);
    assign div_o_valid  = (r_state == S_DONE);
    assign div_o_result = r_result;
    assign div_o_rd     = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Self-checking bench for div_unit. A table of operations is
//               applied in a loop; expected result/rd/latency records are
//               queued when an op is driven and popped when div_o_valid rises.
//               Hand-written sequences cover ignored requests, flush,
//               backpressure and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        div_i_valid;
    logic        div_i_ready;
    logic [3:0]  div_i_div_info;
    logic [3:0]  div_i_rem_info;
    logic [63:0] div_i_src1;
    logic [63:0] div_i_src2;
    logic [4:0]  div_i_rd;
    logic        div_i_flush;
    logic        div_o_valid;
    logic        div_o_ready;
    logic [63:0] div_o_result;
    logic [4:0]  div_o_rd;

    div_unit dut (
        .clk            (clk),
        .rst            (rst),
        .div_i_valid    (div_i_valid),
        .div_i_ready    (div_i_ready),
        .div_i_div_info (div_i_div_info),
        .div_i_rem_info (div_i_rem_info),
        .div_i_src1     (div_i_src1),
        .div_i_src2     (div_i_src2),
        .div_i_rd       (div_i_rd),
        .div_i_flush    (div_i_flush),
        .div_o_valid    (div_o_valid),
        .div_o_ready    (div_o_ready),
        .div_o_result   (div_o_result),
        .div_o_rd       (div_o_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  di;
        logic [3:0]  ri;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic [63:0] res;
        int          lat;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];
    exp_t sb [$];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act !== req) begin
            $display("FAIL %s: got %h expected %h", name, act, req);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle_inputs();
        div_i_valid    = 1'b0;
        div_i_div_info = 4'd0;
        div_i_rem_info = 4'd0;
        div_i_src1     = 64'd0;
        div_i_src2     = 64'd0;
        div_i_rd       = 5'd0;
    endtask

    // Drive one op at a negedge; the following posedge accepts it.
    task automatic drive_op(input vec_t v);
        div_i_valid    = 1'b1;
        div_i_div_info = v.di;
        div_i_rem_info = v.ri;
        div_i_src1     = v.a;
        div_i_src2     = v.b;
        div_i_rd       = v.rd;
    endtask

    // Full transaction: drive, wait for result, compare against the
    // scoreboard, optionally hold off the consumer, then hand-shake.
    task automatic run_op(input vec_t v, input int hold);
        exp_t e;
        int   n;
        chk("ready_before_op", {63'd0, div_i_ready}, 64'd1);
        drive_op(v);
        sb.push_back('{res: v.res, rd: v.rd, lat: v.lat});
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        n = 1;
        while (!div_o_valid && n < 200) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        if (!div_o_valid) begin
            chk("timeout_valid", 64'd0, 64'd1);
        end else begin
            chk("result", div_o_result, e.res);
            chk("rd", {59'd0, div_o_rd}, {59'd0, e.rd});
            chk("latency", 64'(n), 64'(e.lat));
            chk("busy_while_valid", {63'd0, div_i_ready}, 64'd0);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", {63'd0, div_o_valid}, 64'd1);
            chk("hold_result", div_o_result, e.res);
            chk("hold_rd", {59'd0, div_o_rd}, {59'd0, e.rd});
            chk("hold_ready_low", {63'd0, div_i_ready}, 64'd0);
        end
        div_o_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_o_ready = 1'b0;
        chk("ready_after_hs", {63'd0, div_i_ready}, 64'd1);
        chk("valid_after_hs", {63'd0, div_o_valid}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   bad;

        vecs[0]  = '{4'b1000, 4'b0000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd1, 64'hFFFF_FFFF_FFFF_FFFD, 65};
        vecs[1]  = '{4'b0000, 4'b1000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
        vecs[2]  = '{4'b0100, 4'b0000, 64'h1234, 64'd0, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vecs[3]  = '{4'b0000, 4'b0100, 64'h1234, 64'd0, 5'd4, 64'h1234, 1};
        vecs[4]  = '{4'b1000, 4'b0000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 64'h8000_0000_0000_0000, 1};
        vecs[5]  = '{4'b0000, 4'b1000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 64'd0, 1};
        vecs[6]  = '{4'b0010, 4'b0000, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF, 5'd7, 64'hFFFF_FFFF_8000_0000, 1};
        vecs[7]  = '{4'b0000, 4'b0001, 64'h0000_000A_0000_0007, 64'd3, 5'd17, 64'd1, 33};
        vecs[8]  = '{4'b0100, 4'b0000, 64'd100, 64'd7, 5'd9, 64'd14, 65};
        vecs[9]  = '{4'b0001, 4'b0000, 64'h0000_0000_FFFF_FFFF, 64'd1, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 33};
        vecs[10] = '{4'b0010, 4'b0000, 64'h0000_DEAD_FFFF_FF9C, 64'd7, 5'd11, 64'hFFFF_FFFF_FFFF_FFF2, 33};
        vecs[11] = '{4'b0000, 4'b0010, 64'h0000_DEAD_FFFF_FF9C, 64'd7, 5'd12, 64'hFFFF_FFFF_FFFF_FFFE, 33};
        vecs[12] = '{4'b0000, 4'b0100, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 5'd13, 64'hF, 65};
        vecs[13] = '{4'b0100, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd14, 64'd1, 65};
        // multiple info bits set: divu outranks divuw and rem
        vecs[14] = '{4'b0101, 4'b1000, 64'd100, 64'd7, 5'd15, 64'd14, 65};
        // remw outranks remuw
        vecs[15] = '{4'b0000, 4'b0011, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd16, 64'hFFFF_FFFF_FFFF_FFFE, 33};

        rst         = 1'b0;
        div_i_flush = 1'b0;
        div_o_ready = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", {63'd0, div_i_ready}, 64'd1);
        chk("reset_valid", {63'd0, div_o_valid}, 64'd0);
        chk("reset_result", div_o_result, 64'd0);
        chk("reset_rd", {59'd0, div_o_rd}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i], 0);
        end

        // All-zero info is ignored
        div_i_valid = 1'b1;
        div_i_src1  = 64'd50;
        div_i_src2  = 64'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        idle_inputs();
        chk("zero_info_ready", {63'd0, div_i_ready}, 64'd1);
        chk("zero_info_valid", {63'd0, div_o_valid}, 64'd0);

        // Flush coinciding with a request wins
        drive_op(vecs[2]);
        div_i_flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_i_flush = 1'b0;
        idle_inputs();
        chk("flush_vs_req_ready", {63'd0, div_i_ready}, 64'd1);
        chk("flush_vs_req_valid", {63'd0, div_o_valid}, 64'd0);

        // Backpressure: result and rd held for 5 cycles
        run_op(vecs[8], 5);

        // Flush on the 10th CALC cycle
        drive_op(vecs[8]);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        div_i_flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_i_flush = 1'b0;
        chk("flush_calc_ready", {63'd0, div_i_ready}, 64'd1);
        bad = 0;
        repeat (70) begin
            @(posedge clk);
            @(negedge clk);
            if (div_o_valid) bad++;
        end
        chk("flush_calc_no_valid", 64'(bad), 64'd0);
        v = vecs[8];
        v.rd = 5'd21;
        run_op(v, 0);

        // Flush while a result is pending drops it
        drive_op(vecs[3]);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        chk("pending_valid", {63'd0, div_o_valid}, 64'd1);
        div_i_flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_i_flush = 1'b0;
        chk("flush_done_valid", {63'd0, div_o_valid}, 64'd0);
        chk("flush_done_ready", {63'd0, div_i_ready}, 64'd1);

        // Asynchronous reset mid-CALC
        drive_op(vecs[0]);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_ready", {63'd0, div_i_ready}, 64'd1);
        chk("async_rst_valid", {63'd0, div_o_valid}, 64'd0);
        chk("async_rst_result", div_o_result, 64'd0);
        chk("async_rst_rd", {59'd0, div_o_rd}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op(vecs[7], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
